// File: rtl/count_timer_pkg.sv
// Shared helpers for the count_timer interval timer.
package count_timer_pkg;

   localparam int unsigned CT_DEFAULT_STOP_COUNT = 32'd100;

   // Counter width able to hold STOP_COUNT; never below one bit.
   function automatic int unsigned ct_cnt_width(input longint unsigned stop_count);
      int unsigned w;
      w = $clog2(stop_count + 64'd1);
      if (w < 32'd1) begin
         w = 32'd1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/count_timer.sv
// Non-retriggerable one-shot interval timer: a sampled start produces a
// one-cycle done pulse STOP_COUNT edges later; a held start chains intervals.
module count_timer
   import count_timer_pkg::*;
#(
   parameter int unsigned STOP_COUNT = CT_DEFAULT_STOP_COUNT
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic done
);

   localparam int unsigned CW = ct_cnt_width(64'(STOP_COUNT));
   localparam logic [CW-1:0] LAST = CW'(STOP_COUNT - 32'd1);

   generate
      if (STOP_COUNT == 32'd0) begin : g_bad_stop_count
         $fatal(1, "count_timer: STOP_COUNT must be at least 1");
      end
   endgenerate

   logic          running_q, running_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;

   // Next-state: idle waits for start, running counts to LAST then re-samples start.
   always_comb begin
      running_d = running_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      if (!running_q) begin
         if (start) begin
            running_d = 1'b1;
            cnt_d     = '0;
         end else begin
            running_d = 1'b0;
         end
      end else if (cnt_q == LAST) begin
         done_d    = 1'b1;
         cnt_d     = '0;
         running_d = start;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // State registers; reset wins over start on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         running_q <= 1'b0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         running_q <= running_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
      end
   end

   assign done = done_q;

endmodule

// File: tb/tb_count_timer.sv
// Randomised and directed bench for count_timer against an edge-number reference model.
module tb_count_timer;

   logic clk;
   logic rst;
   logic start;
   logic done0, done1, done2;

   count_timer #(.STOP_COUNT(101)) u_dut0 (.clk(clk), .rst(rst), .start(start), .done(done0));
   count_timer #(.STOP_COUNT(900)) u_dut1 (.clk(clk), .rst(rst), .start(start), .done(done1));
   count_timer #(.STOP_COUNT(1))   u_dut2 (.clk(clk), .rst(rst), .start(start), .done(done2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks_n;
   int failures_n;

   longint stop_len [3] = '{64'd101, 64'd900, 64'd1};
   longint edge_n;
   longint due [3];
   bit     busy [3];
   bit     exp_done [3];
   int     pulses [3];
   longint first_rise [3];
   longint e0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks_n++;
      if (obs !== exp) begin
         failures_n++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      for (int i = 0; i < 3; i++) begin
         pulses[i]     = 0;
         first_rise[i] = -64'sd1;
      end
   endtask

   // One clock edge: advance the reference model, then compare every done output.
   task automatic tick();
      logic [2:0] obs;
      @(posedge clk);
      edge_n++;
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            busy[i]     = 1'b0;
            exp_done[i] = 1'b0;
         end else if (busy[i] && edge_n == due[i]) begin
            exp_done[i] = 1'b1;
            busy[i]     = start;
            due[i]      = edge_n + stop_len[i];
         end else if (!busy[i] && start) begin
            busy[i]     = 1'b1;
            due[i]      = edge_n + stop_len[i];
            exp_done[i] = 1'b0;
         end else begin
            exp_done[i] = 1'b0;
         end
      end
      #1;
      obs = {done2, done1, done0};
      for (int i = 0; i < 3; i++) begin
         check($sformatf("done%0d@edge%0d", i, edge_n), 64'(obs[i]), 64'(exp_done[i]));
         if (obs[i]) begin
            pulses[i]++;
            if (first_rise[i] < 0) first_rise[i] = edge_n;
         end
      end
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic launch();
      start = 1'b1;
      tick();
      e0    = edge_n;
      start = 1'b0;
   endtask

   initial begin
      checks_n   = 0;
      failures_n = 0;
      edge_n     = 0;
      for (int i = 0; i < 3; i++) begin
         busy[i]     = 1'b0;
         due[i]      = 0;
         exp_done[i] = 1'b0;
      end
      rst   = 1'b1;
      start = 1'b0;

      // Reset hold with start toggling, then a quiet idle window.
      clear_stats();
      for (int i = 0; i < 5; i++) begin
         start = i[0];
         tick();
      end
      rst   = 1'b0;
      start = 1'b0;
      run(200);
      for (int i = 0; i < 3; i++) check($sformatf("reset_idle_pulses%0d", i), 64'(pulses[i]), 64'd0);

      // Single shot, twice, separated by a gap.
      for (int rep = 0; rep < 2; rep++) begin
         clear_stats();
         launch();
         run(950);
         check("single_rise0", first_rise[0], e0 + 64'd101);
         check("single_rise1", first_rise[1], e0 + 64'd900);
         check("single_rise2", first_rise[2], e0 + 64'd1);
         for (int i = 0; i < 3; i++) check($sformatf("single_pulses%0d", i), 64'(pulses[i]), 64'd1);
         run(20);
      end

      // Back-to-back: start sampled high on 202 consecutive edges.
      clear_stats();
      start = 1'b1;
      tick();
      e0 = edge_n;
      run(201);
      start = 1'b0;
      run(950);
      check("b2b_rise0", first_rise[0], e0 + 64'd101);
      check("b2b_pulses0", 64'(pulses[0]), 64'd2);
      check("b2b_pulses1", 64'(pulses[1]), 64'd1);
      check("b2b_high_cycles2", 64'(pulses[2]), 64'd202);

      // Non-retrigger: second start mid-interval is ignored.
      clear_stats();
      launch();
      run(49);
      start = 1'b1;
      tick();
      start = 1'b0;
      run(950);
      check("noretrig_rise0", first_rise[0], e0 + 64'd101);
      check("noretrig_pulses0", 64'(pulses[0]), 64'd1);
      check("noretrig_pulses1", 64'(pulses[1]), 64'd1);
      check("noretrig_pulses2", 64'(pulses[2]), 64'd2);

      // Reset mid-run aborts; a fresh start times from its own edge.
      clear_stats();
      launch();
      run(59);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      run(9);
      start = 1'b1;
      tick();
      start = 1'b0;
      run(950);
      check("midrst_rise0", first_rise[0], e0 + 64'd171);
      check("midrst_pulses0", 64'(pulses[0]), 64'd1);
      check("midrst_rise1", first_rise[1], e0 + 64'd970);
      check("midrst_pulses2", 64'(pulses[2]), 64'd2);

      // Random start/reset traffic checked cycle by cycle against the model.
      for (int k = 0; k < 3000; k++) begin
         start = ($urandom_range(0, 7) == 0);
         rst   = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst   = 1'b0;
      start = 1'b0;
      run(950);

      $display("TB_RESULT checks=%0d failures=%0d", checks_n, failures_n);
      $finish;
   end

endmodule

// File: doc/count_timer.md
Name: count_timer

Overview:
- Non-retriggerable one-shot interval timer.
- A sampled start request launches a count of STOP_COUNT clock cycles, then a single-cycle done pulse is emitted.
- Holding start high chains intervals back-to-back, producing periodic done pulses every STOP_COUNT cycles.
- Used as a generic delay/timeout building block; several instances with different STOP_COUNT may share one start strobe.

Parameters:
- STOP_COUNT, default 100: interval length in clock cycles, from the start-sampling edge to the done-rising edge. Legal range is 1 to 2^31-1; 0 is illegal and must trigger an elaboration-time error.
- CW (localparam): $clog2(STOP_COUNT+1), the counter width.

Ports:
- clk  input  1  single clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level-sampled request to begin an interval.
- done  output  1  registered, one-cycle pulse marking interval completion.

Behaviour:
- State: running flag (1 bit) and cnt (CW bits).
- Reset (rst high at an edge): running=0, cnt=0, done=0. Reset has priority over every other input, including start on the same edge.
- Reset mid-interval aborts silently; no done pulse is produced.
- Idle (running=0): at an edge with start=1, set running=1 and cnt=0. Call this edge E0. With start=0 the block stays idle and done=0.
- Running, cnt != STOP_COUNT-1: cnt increments by 1 each edge and done=0. start is ignored (no retrigger, no extension).
- Running, cnt == STOP_COUNT-1, at edge E0+STOP_COUNT:
  - done<=1 for exactly this one cycle.
  - cnt<=0.
  - running<=start.
  - If start=1 at this edge, this edge is the new E0 and the next done rises at E0+2*STOP_COUNT; otherwise the block returns to idle.
- Latency: done is high in the cycle following edge E0+STOP_COUNT. Counting edges after E0, done rises exactly STOP_COUNT edges later.
- done is never high two consecutive cycles, except when STOP_COUNT=1 and start is held high, in which case done stays high continuously.
- STOP_COUNT=1: done rises at the edge after the start-sampling edge.
- start pulses shorter than one cycle between edges are not seen; only the edge-sampled value matters.
- The counter never wraps: its maximum value is STOP_COUNT-1, and CW guarantees range.
- No combinational path from any input to done.

Decomposition:
- No shared package is required; STOP_COUNT is a per-instance parameter.
- Single flat module, no sub-modules. The counter and control fit in one always block plus a done register.

Test Plan:
- Reset hold: rst=1 for 5 cycles with start toggling -> done=0 throughout; no pulse within 200 cycles after release with start=0.
- Single shot: two instances (STOP_COUNT=101 and 900) sharing one start strobe; start high for one edge -> done0 rises exactly 101 edges later and done1 exactly 900 edges later, each for one cycle. Repeat after a 20-cycle gap -> identical results.
- Back-to-back: STOP_COUNT=101, start held high -> done pulses at +101 and +202, each one cycle wide, low in between. Deassert start -> idle, no further pulses.
- Non-retrigger: STOP_COUNT=101, start pulsed at E0 and again at E0+50 -> a single done at E0+101 only.
- Reset mid-run: STOP_COUNT=101, start at E0, rst at E0+60 -> no done. A fresh start at E0+70 -> done at E0+171.
- Edge case: STOP_COUNT=1, one-cycle start -> done high exactly one cycle, one edge after the sampling edge.
